// File: rtl/snoop_pkg.sv
// rtl/snoop_pkg.sv - shared types, index-width helper and CR decode constant for the snoop mux
//   ac_chan_t / cr_chan_t / cd_chan_t : default snoop channel payloads
//   snoop_req_t / snoop_resp_t        : default snoop port request / response structs
package snoop_pkg;

    // Bit of the CR response that announces a following CD burst (DataTransfer).
    localparam int unsigned CrDataTransferBit = 0;

    // Port index width; a single port still gets a 1-bit index so the datapath is uniform.
    function automatic int unsigned idx_width(input int unsigned num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  prot;
    } ac_chan_t;

    typedef logic [4:0] cr_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } cd_chan_t;

    typedef struct packed {
        ac_chan_t ac;
        logic     ac_valid;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        cr_chan_t cr_resp;
        logic     cd_valid;
        cd_chan_t cd;
    } snoop_resp_t;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - small synchronous FIFO, accepts a push while full when a pop happens in the same cycle
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   flush_i        : drop all entries
//   testmode_i     : test mode (no effect on this storage)
//   full_o/empty_o : status, usage_o : entry count
//   data_i/push_i  : write side, data_o/pop_i : read side (head shown on data_o)
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CntW-1:0]       usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam logic [AddrW-1:0] LastPtr = AddrW'(DEPTH - 1);
    localparam logic [CntW-1:0]  FullCnt = CntW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  push_ok, pop_ok;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;
    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/rr_arb_tree.sv
// rtl/rr_arb_tree.sv - round-robin arbiter with valid/ready lock-in
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i/gnt_o   : per-input request and grant
//   data_i        : per-input payload
//   req_o/gnt_i   : arbitrated request and downstream grant
//   data_o/idx_o  : winning payload and index
module rr_arb_tree #(
    parameter int unsigned NumIn    = 4,
    parameter type         DataType = logic,
    parameter bit          LockIn   = 1'b1,
    localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumIn-1:0]          req_i,
    output logic [NumIn-1:0]          gnt_o,
    input  DataType [NumIn-1:0]       data_i,
    output logic                      req_o,
    input  logic                      gnt_i,
    output DataType                   data_o,
    output logic [IdxWidth-1:0]       idx_o
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumIn - 1);

    logic [IdxWidth-1:0] rr_q, rr_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
    logic                lock_q, lock_d;
    logic [IdxWidth-1:0] sel, cand;
    logic                found;

    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        // First requester at or after the round-robin pointer, wrapping around.
        for (int unsigned k = 0; k < NumIn; k++) begin
            cand = IdxWidth'((32'(rr_q) + k) % NumIn);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        // A presented but not yet accepted request keeps its slot until accepted.
        if (LockIn && lock_q) begin
            sel = lock_idx_q;
        end

        req_o      = req_i[sel];
        data_o     = data_i[sel];
        idx_o      = sel;
        gnt_o      = '0;
        gnt_o[sel] = req_o & gnt_i;

        lock_d     = LockIn && req_o && !gnt_i;
        lock_idx_d = sel;
        rr_d       = rr_q;
        if (req_o && gnt_i) begin
            rr_d = (sel == LastIdx) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/spill_register.sv
// rtl/spill_register.sv - one-stage valid/ready pipeline register
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   valid_i/ready_o/data_i  : upstream handshake and payload
//   valid_o/ready_i/data_o  : downstream handshake and payload
module spill_register #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    logic valid_q, valid_d;
    T     data_q, data_d;

    // Accept a new beat whenever the stage is empty or is draining this cycle.
    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_i && ready_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/snoop_mux_mo.sv
// rtl/snoop_mux_mo.sv - multi-outstanding snoop mux: AC arbitration, in-order CR/CD return routing
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   test_i        : test mode, passed to the index FIFOs
//   slv_reqs_i    : NoSlvPorts slave snoop requests    slv_resps_o : matching responses
//   mst_req_o     : master snoop request               mst_resp_i  : master snoop response
//   Build option SNOOP_MUX_AC_SPILL_EN: register the master AC output (1-cycle AC latency).
module snoop_mux_mo #(
    parameter int unsigned NoSlvPorts = 4,
    parameter int unsigned MaxTrans   = 4,
    parameter type ac_chan_t    = snoop_pkg::ac_chan_t,
    parameter type cr_chan_t    = snoop_pkg::cr_chan_t,
    parameter type cd_chan_t    = snoop_pkg::cd_chan_t,
    parameter type snoop_req_t  = snoop_pkg::snoop_req_t,
    parameter type snoop_resp_t = snoop_pkg::snoop_resp_t
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         test_i,
    input  snoop_req_t  [NoSlvPorts-1:0] slv_reqs_i,
    output snoop_resp_t [NoSlvPorts-1:0] slv_resps_o,
    output snoop_req_t                   mst_req_o,
    input  snoop_resp_t                  mst_resp_i
);

    import snoop_pkg::*;

    localparam int unsigned IdxWidth = idx_width(NoSlvPorts);
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTrans);

    logic [CntWidth-1:0]         cnt_q, cnt_d;
    logic                        ac_ok;
    logic [NoSlvPorts-1:0]       arb_req_in, arb_gnt_vec;
    ac_chan_t [NoSlvPorts-1:0]   arb_data;
    ac_chan_t                    arb_ac, mst_ac;
    logic                        arb_req, arb_gnt, mst_ac_valid;
    logic [IdxWidth-1:0]         arb_idx;
    logic                        ac_hs, cr_hs, cr_data, cd_hs, cd_done;
    logic                        mst_cr_ready, mst_cd_ready;
    logic [IdxWidth-1:0]         cr_head, cd_head;
    logic                        cr_empty, cd_empty;
    logic [NoSlvPorts-1:0]       cr_valid_vec, cd_valid_vec;

    // New snoops are only admitted while fewer than MaxTrans are outstanding.
    assign ac_ok = (cnt_q < MaxCnt);

    always_comb begin
        arb_req_in = '0;
        arb_data   = '0;
        for (int i = 0; i < NoSlvPorts; i++) begin
            arb_req_in[i] = slv_reqs_i[i].ac_valid && ac_ok;
            arb_data[i]   = slv_reqs_i[i].ac;
        end
    end

    rr_arb_tree #(
        .NumIn    (NoSlvPorts),
        .DataType (ac_chan_t),
        .LockIn   (1'b1)
    ) i_ac_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (arb_req_in),
        .gnt_o  (arb_gnt_vec),
        .data_i (arb_data),
        .req_o  (arb_req),
        .gnt_i  (arb_gnt),
        .data_o (arb_ac),
        .idx_o  (arb_idx)
    );

`ifdef SNOOP_MUX_AC_SPILL_EN
    // The snoop counts as issued once it is inside the spill stage.
    spill_register #(
        .T (ac_chan_t)
    ) i_ac_spill (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (arb_req),
        .ready_o (arb_gnt),
        .data_i  (arb_ac),
        .valid_o (mst_ac_valid),
        .ready_i (mst_resp_i.ac_ready),
        .data_o  (mst_ac)
    );
`else
    assign mst_ac_valid = arb_req;
    assign mst_ac       = arb_req ? arb_ac : '0;
    assign arb_gnt      = mst_resp_i.ac_ready;
`endif

    assign ac_hs        = arb_req && arb_gnt;
    assign mst_cr_ready = !cr_empty && slv_reqs_i[cr_head].cr_ready;
    assign mst_cd_ready = !cd_empty && slv_reqs_i[cd_head].cd_ready;
    assign cr_hs        = mst_resp_i.cr_valid && mst_cr_ready;
    assign cr_data      = mst_resp_i.cr_resp[CrDataTransferBit];
    assign cd_hs        = mst_resp_i.cd_valid && mst_cd_ready;
    assign cd_done      = cd_hs && mst_resp_i.cd.last;

    // Issue order of snoops, consumed by CR responses.
    fifo_v3 #(
        .DATA_WIDTH (IdxWidth),
        .DEPTH      (MaxTrans)
    ) i_cr_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (test_i),
        .full_o     (),
        .empty_o    (cr_empty),
        .usage_o    (),
        .data_i     (arb_idx),
        .push_i     (ac_hs),
        .data_o     (cr_head),
        .pop_i      (cr_hs)
    );

    // Order of snoops that announced data, consumed by CD bursts.
    fifo_v3 #(
        .DATA_WIDTH (IdxWidth),
        .DEPTH      (MaxTrans)
    ) i_cd_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (test_i),
        .full_o     (),
        .empty_o    (cd_empty),
        .usage_o    (),
        .data_i     (cr_head),
        .push_i     (cr_hs && cr_data),
        .data_o     (cd_head),
        .pop_i      (cd_done)
    );

    always_comb begin
        mst_req_o          = '0;
        mst_req_o.ac_valid = mst_ac_valid;
        mst_req_o.ac       = mst_ac;
        mst_req_o.cr_ready = mst_cr_ready;
        mst_req_o.cd_ready = mst_cd_ready;

        slv_resps_o  = '0;
        cr_valid_vec = '0;
        cd_valid_vec = '0;
        for (int i = 0; i < NoSlvPorts; i++) begin
            slv_resps_o[i].ac_ready = arb_gnt_vec[i];
            if (!cr_empty && (cr_head == IdxWidth'(i))) begin
                slv_resps_o[i].cr_valid = mst_resp_i.cr_valid;
                slv_resps_o[i].cr_resp  = mst_resp_i.cr_resp;
            end
            if (!cd_empty && (cd_head == IdxWidth'(i))) begin
                slv_resps_o[i].cd_valid = mst_resp_i.cd_valid;
                slv_resps_o[i].cd       = mst_resp_i.cd;
            end
            cr_valid_vec[i] = slv_resps_o[i].cr_valid;
            cd_valid_vec[i] = slv_resps_o[i].cd_valid;
        end

        // A data-less CR retires its snoop; a data snoop retires on its last CD beat.
        cnt_d = cnt_q + CntWidth'(ac_hs)
                      - CntWidth'(cr_hs && !cr_data)
                      - CntWidth'(cd_done);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    a_cr_valid_needs_entry : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((|cr_valid_vec) && cr_empty));
    a_cd_valid_needs_entry : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((|cd_valid_vec) && cd_empty));
    a_cnt_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= MaxCnt);

endmodule
